// File: rtl/fetch_queue_pkg.sv
// Shared widths, queue entry layout and pointer sizing for the instruction-fetch queue.
package fetch_queue_pkg;
   localparam int ADDR_LEN  = 32;
   localparam int INSTR_LEN = 32;

   typedef logic [ADDR_LEN-1:0]  addr_t;
   typedef logic [INSTR_LEN-1:0] inst_t;

   typedef struct packed {
      addr_t pc;
      inst_t inst;
   } ifq_entry_t;

   function automatic int ifq_ptr_w(input int depth);
      return $clog2(depth);
   endfunction
endpackage

// File: rtl/ifq_ring_buffer.sv
// Entry array for the fetch queue: allocate at tail on request accept, fill in order on response, pop at head.
// Pointers carry a wrap bit so occupancy and pending counts fall out of plain subtraction.
module ifq_ring_buffer
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = ifq_ptr_w(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 alloc,
   input  logic [ADDR_LEN-1:0]  alloc_pc,
   input  logic                 fill,
   input  logic [INSTR_LEN-1:0] fill_inst,
   input  logic                 pop,
   output logic [PTR_W:0]       occupancy,
   output logic [PTR_W:0]       pending,
   output logic                 head_ok,
   output logic [ADDR_LEN-1:0]  head_pc,
   output logic [INSTR_LEN-1:0] head_inst
);
   localparam logic [PTR_W:0] PTR_ONE = 1;

   logic [PTR_W:0]   tail;
   logic [PTR_W:0]   fill_ptr;
   logic [PTR_W:0]   head;
   logic [PTR_W-1:0] tail_idx;
   logic [PTR_W-1:0] fill_idx;
   logic [PTR_W-1:0] head_idx;
   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] data_ok;
   ifq_entry_t       ent [DEPTH];

   assign tail_idx  = tail[PTR_W-1:0];
   assign fill_idx  = fill_ptr[PTR_W-1:0];
   assign head_idx  = head[PTR_W-1:0];
   assign occupancy = tail - head;
   assign pending   = tail - fill_ptr;
   assign head_ok   = valid[head_idx] && data_ok[head_idx];
   // Fields read as zero while the head is not deliverable, which also gives clean reset values.
   assign head_pc   = head_ok ? ent[head_idx].pc : '0;
   assign head_inst = head_ok ? ent[head_idx].inst : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tail     <= '0;
         fill_ptr <= '0;
         head     <= '0;
         valid    <= '0;
         data_ok  <= '0;
      end else if (flush) begin
         tail     <= '0;
         fill_ptr <= '0;
         head     <= '0;
         valid    <= '0;
         data_ok  <= '0;
      end else begin
         if (alloc) begin
            valid[tail_idx]   <= 1'b1;
            data_ok[tail_idx] <= 1'b0;
            tail              <= tail + PTR_ONE;
         end
         if (fill) begin
            data_ok[fill_idx] <= 1'b1;
            fill_ptr          <= fill_ptr + PTR_ONE;
         end
         if (pop) begin
            valid[head_idx]   <= 1'b0;
            data_ok[head_idx] <= 1'b0;
            head              <= head + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (alloc) ent[tail_idx].pc <= alloc_pc;
      if (fill) ent[fill_idx].inst <= fill_inst;
   end
endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: credit-limited sequential fetch, in-order response buffering, redirect flush with drop counting.
// Accept at T, response at T+1, out_valid at T+2; optional perf counters under IFQ_PERF_CNT_EN.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int                  DEPTH    = 4,
   parameter logic [ADDR_LEN-1:0] RESET_PC = 32'h0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 redirect_valid,
   input  logic [ADDR_LEN-1:0]  redirect_pc,
   output logic                 imem_req_valid,
   input  logic                 imem_req_ready,
   output logic [ADDR_LEN-1:0]  imem_req_addr,
   input  logic                 imem_resp_valid,
   input  logic [INSTR_LEN-1:0] imem_resp_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [INSTR_LEN-1:0] out_inst,
   output logic [ADDR_LEN-1:0]  out_pc,
   output logic [ADDR_LEN-1:0]  out_pc_plus_4
`ifdef IFQ_PERF_CNT_EN
   ,
   output logic [31:0]          perf_fetch_cnt,
   output logic [31:0]          perf_drop_cnt
`endif
);
   localparam int               PTR_W   = ifq_ptr_w(DEPTH);
   localparam int               CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);

   logic [ADDR_LEN-1:0]  fetch_pc;
   logic [CNT_W-1:0]     drop_cnt;
   logic [CNT_W-1:0]     occupancy;
   logic [CNT_W-1:0]     pending;
   logic [CNT_W-1:0]     in_flight;
   logic [CNT_W:0]       credit_used;
   logic                 req_fire;
   logic                 resp_keep;
   logic                 resp_squash;
   logic                 pop;
   logic                 head_ok;
   logic [ADDR_LEN-1:0]  head_pc;
   logic [INSTR_LEN-1:0] head_inst;

   // Stale responses still hold a credit until they come back and are discarded.
   assign credit_used    = {1'b0, occupancy} + {1'b0, drop_cnt};
   assign in_flight      = pending + drop_cnt;
   assign imem_req_valid = rst && !redirect_valid && (credit_used < DEPTH_C);
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign resp_keep      = imem_resp_valid && !redirect_valid && (drop_cnt == '0) && (pending != '0);
   assign resp_squash    = imem_resp_valid && (redirect_valid ? (in_flight != '0) : (drop_cnt != '0));
   assign out_valid      = head_ok && !redirect_valid;
   assign pop            = out_valid && out_ready;
   assign out_pc         = head_pc;
   assign out_inst       = head_inst;
   assign out_pc_plus_4  = head_ok ? head_pc + ADDR_LEN'(4) : '0;

   ifq_ring_buffer #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_ring (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .alloc     (req_fire),
      .alloc_pc  (fetch_pc),
      .fill      (resp_keep),
      .fill_inst (imem_resp_data),
      .pop       (pop),
      .occupancy (occupancy),
      .pending   (pending),
      .head_ok   (head_ok),
      .head_pc   (head_pc),
      .head_inst (head_inst)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc <= RESET_PC;
         drop_cnt <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc;
         // A response landing in the redirect cycle is already answered and discarded.
         drop_cnt <= (imem_resp_valid && (in_flight != '0)) ? in_flight - CNT_ONE : in_flight;
      end else begin
         if (req_fire) fetch_pc <= fetch_pc + ADDR_LEN'(4);
         if (resp_squash) drop_cnt <= drop_cnt - CNT_ONE;
      end
   end

   resp_has_owner: assert property (@(posedge clk) disable iff (!rst)
      imem_resp_valid |-> (in_flight != '0));

`ifdef IFQ_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetch_cnt <= '0;
         perf_drop_cnt  <= '0;
      end else begin
         if (req_fire) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (resp_squash) perf_drop_cnt <= perf_drop_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory model plus a queue-level reference of issue credit and delivered program order.
module tb_fetch_queue;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus_4;
`ifdef IFQ_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_drop_cnt;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
      .out_pc_plus_4(out_pc_plus_4)
`ifdef IFQ_PERF_CNT_EN
      , .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
   );

   typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
   typedef struct { logic [31:0] pc; bit arrived; } live_t;

   mreq_t       mq[$];      // requests the memory still owes, in order
   live_t       lq[$];      // current-epoch fetches not yet consumed by decode
   int          cyc = 0, cur_epoch = 0, last_due = 0, dmin = 1, dmax = 1;
   int          m_fetch = 0, m_drop = 0;
   logic [31:0] next_req = RESET_PC, prog_pc = RESET_PC;
   logic        o_req_valid, o_out_valid, e_req_valid, e_out_valid;
   logic [31:0] o_addr, o_pc, o_inst, o_pc4, e_addr, e_pc, e_inst, e_prog_pc;
   bit          acc, popped;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return (a * 32'h0100_0193) ^ 32'hC0DE_5EED;
   endfunction

   function automatic int stale_cnt();
      int n = 0;
      foreach (mq[i]) if (mq[i].epoch != cur_epoch) n++;
      return n;
   endfunction

   task automatic model_reset();
      mq.delete();
      lq.delete();
      cur_epoch++;
      next_req = RESET_PC;
      prog_pc = RESET_PC;
      m_fetch = 0;
      m_drop = 0;
      imem_resp_valid = 1'b0;
   endtask

   // One cycle: expectations from model state, observe DUT, advance model and memory.
   task automatic tick();
      bit marked;
      int due;
      mreq_t f;
      #1;
      e_req_valid = !redirect_valid && ((lq.size() + stale_cnt()) < DEPTH);
      e_addr = next_req;
      e_out_valid = 1'b0;
      e_pc = '0;
      if (!redirect_valid && lq.size() > 0) begin
         e_out_valid = lq[0].arrived;
         e_pc = lq[0].pc;
      end
      e_inst = inst_of(e_pc);
      e_prog_pc = prog_pc;
      o_req_valid = imem_req_valid;
      o_addr = imem_req_addr;
      o_out_valid = out_valid;
      o_pc = out_pc;
      o_inst = out_inst;
      o_pc4 = out_pc_plus_4;
      acc = o_req_valid && imem_req_ready;
      popped = o_out_valid && out_ready;
      if (imem_resp_valid && mq.size() > 0) begin
         f = mq.pop_front();
         if (f.epoch != cur_epoch || redirect_valid) m_drop++;
         else begin
            marked = 0;
            for (int i = 0; i < lq.size(); i++)
               if (!marked && !lq[i].arrived) begin
                  lq[i].arrived = 1;
                  marked = 1;
               end
         end
      end
      if (redirect_valid) begin
         lq.delete();
         cur_epoch++;
         next_req = redirect_pc;
         prog_pc = redirect_pc;
      end else begin
         if (popped && lq.size() > 0) begin
            void'(lq.pop_front());
            prog_pc += 32'd4;
         end
         if (acc) begin
            lq.push_back('{next_req, 1'b0});
            next_req += 32'd4;
         end
      end
      if (acc) begin
         due = cyc + $urandom_range(dmax, dmin);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         mq.push_back('{o_addr, redirect_valid ? -1 : cur_epoch, due});
         m_fetch++;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data = inst_of(mq[0].addr);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data = $urandom;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      redirect_valid = 1'b0;
      out_ready = 1'b0;
      imem_req_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_valids req_valid=%b out_valid=%b required 0 0", imem_req_valid, out_valid);
      end
      checks++;
      if (out_inst !== '0 || out_pc !== '0 || out_pc_plus_4 !== '0) begin
         failures++;
         $display("FAIL reset_fields inst=%h pc=%h pc4=%h required 0", out_inst, out_pc, out_pc_plus_4);
      end
      @(negedge clk);
      do_reset();
   endtask

   task automatic test_basic();
      int first_acc = -1, first_out = -1, n_pop = 0;
      do_reset();
      dmin = 1; dmax = 1;
      imem_req_ready = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         tick();
         checks++;
         if (o_req_valid !== e_req_valid || (e_req_valid && o_addr !== e_addr)) begin
            failures++;
            $display("FAIL basic_req cyc=%0d got v=%b a=%h required v=%b a=%h", k, o_req_valid, o_addr, e_req_valid, e_addr);
         end
         checks++;
         if (o_out_valid !== e_out_valid || (e_out_valid && (o_pc !== e_pc || o_inst !== e_inst || o_pc4 !== e_pc + 32'd4))) begin
            failures++;
            $display("FAIL basic_out cyc=%0d got v=%b pc=%h required v=%b pc=%h", k, o_out_valid, o_pc, e_out_valid, e_pc);
         end
         if (acc && first_acc < 0) first_acc = k;
         if (o_out_valid && first_out < 0) first_out = k;
         if (popped) n_pop++;
      end
      checks++;
      if (first_acc != 0 || first_out != 2) begin
         failures++;
         $display("FAIL basic_latency first_acc=%0d first_out=%0d required 0 2", first_acc, first_out);
      end
      checks++;
      if (n_pop != 14) begin
         failures++;
         $display("FAIL basic_throughput pops=%0d required 14", n_pop);
      end
   endtask

   task automatic test_stall();
      int n_acc = 0, n_pop = 0;
      logic [31:0] drained[4];
      logic [31:0] resume_addr = 32'hFFFF_FFFF;
      do_reset();
      dmin = 1; dmax = 1;
      imem_req_ready = 1'b1;
      out_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (acc) n_acc++;
         checks++;
         if (o_out_valid !== e_out_valid || (o_out_valid && o_pc !== RESET_PC)) begin
            failures++;
            $display("FAIL stall_head cyc=%0d got v=%b pc=%h required v=%b pc=%h", k, o_out_valid, o_pc, e_out_valid, RESET_PC);
         end
      end
      checks++;
      if (n_acc != DEPTH || o_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL stall_credit accepts=%0d req_valid=%b required %0d 0", n_acc, o_req_valid, DEPTH);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         checks++;
         if (o_req_valid !== e_req_valid || (e_req_valid && o_addr !== e_addr)) begin
            failures++;
            $display("FAIL stall_req cyc=%0d got v=%b a=%h required v=%b a=%h", k, o_req_valid, o_addr, e_req_valid, e_addr);
         end
         if (acc && resume_addr === 32'hFFFF_FFFF) resume_addr = o_addr;
         if (popped && n_pop < 4) begin
            drained[n_pop] = o_pc;
            n_pop++;
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= n_pop || drained[i] !== 32'(4 * i)) begin
            failures++;
            $display("FAIL stall_drain idx=%0d got %h required %h", i, drained[i], 32'(4 * i));
         end
      end
      checks++;
      if (resume_addr !== 32'h10) begin
         failures++;
         $display("FAIL stall_resume got %h required 00000010", resume_addr);
      end
   endtask

   task automatic test_redirect_outstanding();
      logic [31:0] first_pc = 32'hFFFF_FFFF;
      do_reset();
      dmin = 3; dmax = 3;
      imem_req_ready = 1'b1;
      out_ready = 1'b1;
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      tick();
      checks++;
      if (o_req_valid !== 1'b0 || o_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL redir_quiet req_valid=%b out_valid=%b required 0 0", o_req_valid, o_out_valid);
      end
      redirect_valid = 1'b0;
      dmin = 1; dmax = 1;
      for (int k = 0; k < 15; k++) begin
         tick();
         checks++;
         if (o_req_valid !== e_req_valid || (e_req_valid && o_addr !== e_addr)) begin
            failures++;
            $display("FAIL redir_req cyc=%0d got v=%b a=%h required v=%b a=%h", k, o_req_valid, o_addr, e_req_valid, e_addr);
         end
         if (o_out_valid && first_pc === 32'hFFFF_FFFF) first_pc = o_pc;
      end
      checks++;
      if (first_pc !== 32'h100) begin
         failures++;
         $display("FAIL redir_first_pc got %h required 00000100", first_pc);
      end
`ifdef IFQ_PERF_CNT_EN
      checks++;
      if (perf_drop_cnt !== 32'd2) begin
         failures++;
         $display("FAIL redir_perf_drop got %0d required 2", perf_drop_cnt);
      end
`endif
   endtask

   task automatic test_redirect_same_cycle();
      logic [31:0] first_pc = 32'hFFFF_FFFF;
      do_reset();
      dmin = 2; dmax = 2;
      imem_req_ready = 1'b1;
      out_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      tick();
      checks++;
      if (o_out_valid !== 1'b0 || o_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL same_cycle_r out_valid=%b req_valid=%b required 0 0", o_out_valid, o_req_valid);
      end
      redirect_valid = 1'b0;
      tick();
      checks++;
      if (o_req_valid !== 1'b1 || o_addr !== 32'h200) begin
         failures++;
         $display("FAIL same_cycle_r1 req_valid=%b addr=%h required 1 00000200", o_req_valid, o_addr);
      end
      imem_req_ready = 1'b1;
      dmin = 1; dmax = 1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (o_out_valid && first_pc === 32'hFFFF_FFFF) first_pc = o_pc;
      end
      checks++;
      if (first_pc !== 32'h200) begin
         failures++;
         $display("FAIL same_cycle_first_pc got %h required 00000200", first_pc);
      end
   endtask

   task automatic random_cycles(input int n, output int n_pop);
      n_pop = 0;
      dmin = 1; dmax = 4;
      for (int k = 0; k < n; k++) begin
         imem_req_ready = ($urandom_range(3, 0) != 0);
         out_ready = ($urandom_range(2, 0) != 0);
         redirect_valid = ($urandom_range(24, 0) == 0);
         redirect_pc = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
         tick();
         checks++;
         if (o_req_valid !== e_req_valid || (e_req_valid && o_addr !== e_addr)) begin
            failures++;
            $display("FAIL rnd_req cyc=%0d got v=%b a=%h required v=%b a=%h", cyc, o_req_valid, o_addr, e_req_valid, e_addr);
         end
         checks++;
         if (o_out_valid !== e_out_valid || (e_out_valid && (o_pc !== e_pc || o_inst !== e_inst || o_pc4 !== e_pc + 32'd4))) begin
            failures++;
            $display("FAIL rnd_out cyc=%0d got v=%b pc=%h inst=%h pc4=%h required v=%b pc=%h inst=%h", cyc, o_out_valid, o_pc, o_inst, o_pc4, e_out_valid, e_pc, e_inst);
         end
         if (popped) begin
            n_pop++;
            checks++;
            if (o_pc !== e_prog_pc) begin
               failures++;
               $display("FAIL rnd_order cyc=%0d got pc=%h required %h", cyc, o_pc, e_prog_pc);
            end
         end
      end
      redirect_valid = 1'b0;
   endtask

   task automatic test_random();
      int n_pop;
      do_reset();
      random_cycles(3000, n_pop);
      checks++;
      if (n_pop < 300) begin
         failures++;
         $display("FAIL rnd_progress pops=%0d required at least 300", n_pop);
      end
`ifdef IFQ_PERF_CNT_EN
      checks++;
      if (perf_fetch_cnt !== 32'(m_fetch) || perf_drop_cnt !== 32'(m_drop)) begin
         failures++;
         $display("FAIL rnd_perf fetch=%0d drop=%0d required %0d %0d", perf_fetch_cnt, perf_drop_cnt, m_fetch, m_drop);
      end
`endif
   endtask

   task automatic test_async_reset();
      int n_pop;
      random_cycles(40, n_pop);
      #3;
      rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL areset_valids out_valid=%b req_valid=%b required 0 0", out_valid, imem_req_valid);
      end
      checks++;
      if (out_inst !== '0 || out_pc !== '0 || out_pc_plus_4 !== '0) begin
         failures++;
         $display("FAIL areset_fields inst=%h pc=%h pc4=%h required 0", out_inst, out_pc, out_pc_plus_4);
      end
`ifdef IFQ_PERF_CNT_EN
      checks++;
      if (perf_fetch_cnt !== '0 || perf_drop_cnt !== '0) begin
         failures++;
         $display("FAIL areset_perf fetch=%0d drop=%0d required 0 0", perf_fetch_cnt, perf_drop_cnt);
      end
`endif
      redirect_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      imem_req_ready = 1'b1;
      out_ready = 1'b1;
      dmin = 1; dmax = 1;
      tick();
      checks++;
      if (o_req_valid !== 1'b1 || o_addr !== RESET_PC) begin
         failures++;
         $display("FAIL areset_first_addr req_valid=%b addr=%h required 1 %h", o_req_valid, o_addr, RESET_PC);
      end
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (o_out_valid !== e_out_valid || (e_out_valid && o_pc !== e_pc)) begin
            failures++;
            $display("FAIL areset_out cyc=%0d got v=%b pc=%h required v=%b pc=%h", k, o_out_valid, o_pc, e_out_valid, e_pc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_redirect_outstanding();
      test_redirect_same_cycle();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
